// File: rtl/cfg_chain_loader.sv
// Configuration chain loader: takes bitstream words over a valid/ready handshake and shifts
// them LSB-first, CONFIG_WIDTH bits per cycle, into a configuration scan chain.
module cfg_chain_loader #(
  parameter int unsigned CONFIG_WIDTH = 1,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned CHAIN_LEN    = 16
) (
  input  logic                    config_clk,
  input  logic                    config_rst,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    config_en,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned SlicesPerWord = WORD_WIDTH / CONFIG_WIDTH;
  localparam int unsigned TotalSlices   = CHAIN_LEN / CONFIG_WIDTH;
  localparam int unsigned CntW          = $clog2(TotalSlices + 1);
  localparam int unsigned IdxW          = (SlicesPerWord > 1) ? $clog2(SlicesPerWord) : 1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(SlicesPerWord - 1);
  localparam logic [CntW-1:0] LastCnt   = CntW'(TotalSlices - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                  state_q;
  logic [WORD_WIDTH-1:0]   word_q;
  logic                    word_valid_q;
  logic [IdxW-1:0]         idx_q;
  logic [CntW-1:0]         cnt_q;

  logic                    shift;
  logic                    accept;
  logic                    last_slice;
  logic [CONFIG_WIDTH-1:0] slice;
  int unsigned             covered;

  // Handshake, shift enable and current slice, all derived from the buffer state.
  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < SlicesPerWord; k++) begin
      if (idx_q == IdxW'(k)) slice = word_q[k*CONFIG_WIDTH +: CONFIG_WIDTH];
    end

    // Slices already shifted plus those still waiting in the buffer.
    covered = 32'(cnt_q);
    if (word_valid_q) covered = covered + SlicesPerWord - 32'(idx_q);

    last_slice = word_valid_q && (idx_q == LastIdx);
    shift      = (state_q == StLoad) && word_valid_q;
    // Refill while the last slice drains so consecutive words shift without a bubble.
    word_ready = (state_q == StLoad) && (covered < TotalSlices) && (!word_valid_q || last_slice);
    accept     = word_ready && word_valid;

    config_en  = shift;
    config_out = shift ? slice : '0;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
  end

  // Load FSM with word buffer, slice index and shifted-slice counter.
  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state_q      <= StIdle;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StLoad;
            word_valid_q <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
          end
        end
        StLoad: begin
          if (shift) begin
            cnt_q <= cnt_q + CntW'(1);
            if (last_slice) begin
              idx_q        <= '0;
              word_valid_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
          if (accept) begin
            word_q       <= word_in;
            word_valid_q <= 1'b1;
            idx_q        <= '0;
          end
          // Chain full: leftover slices of the final word are dropped.
          if (shift && (cnt_q == LastCnt)) begin
            state_q      <= StDone;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            idx_q        <= '0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: three instances cover the 1-bit/16-bit chain,
// a 12-bit chain with a partial final word, and a 2-bit-wide chain.
module tb_cfg_chain_loader;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Instance A: CONFIG_WIDTH=1, WORD_WIDTH=8, CHAIN_LEN=16
  logic       start_a, valid_a, ready_a, en_a, out_a, busy_a, done_a;
  logic [7:0] word_a;
  logic [15:0] chain_a;
  // Instance B: CONFIG_WIDTH=1, WORD_WIDTH=8, CHAIN_LEN=12
  logic       start_b, valid_b, ready_b, en_b, out_b, busy_b, done_b;
  logic [7:0] word_b;
  logic [11:0] chain_b;
  // Instance C: CONFIG_WIDTH=2, WORD_WIDTH=8, CHAIN_LEN=32
  logic       start_c, valid_c, ready_c, en_c, busy_c, done_c;
  logic [1:0] out_c;
  logic [7:0] word_c;
  logic [31:0] chain_c;

  cfg_chain_loader #(.CONFIG_WIDTH(1), .WORD_WIDTH(8), .CHAIN_LEN(16)) u_a (
    .config_clk(clk), .config_rst(rst), .start(start_a), .word_in(word_a),
    .word_valid(valid_a), .word_ready(ready_a), .config_en(en_a), .config_out(out_a),
    .busy(busy_a), .done(done_a)
  );

  cfg_chain_loader #(.CONFIG_WIDTH(1), .WORD_WIDTH(8), .CHAIN_LEN(12)) u_b (
    .config_clk(clk), .config_rst(rst), .start(start_b), .word_in(word_b),
    .word_valid(valid_b), .word_ready(ready_b), .config_en(en_b), .config_out(out_b),
    .busy(busy_b), .done(done_b)
  );

  cfg_chain_loader #(.CONFIG_WIDTH(2), .WORD_WIDTH(8), .CHAIN_LEN(32)) u_c (
    .config_clk(clk), .config_rst(rst), .start(start_c), .word_in(word_c),
    .word_valid(valid_c), .word_ready(ready_c), .config_en(en_c), .config_out(out_c),
    .busy(busy_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan-chain models: new slice enters at the top, first slice ends up in the low bits.
  always @(posedge clk) if (en_a) chain_a <= {out_a, chain_a[15:1]};
  always @(posedge clk) if (en_b) chain_b <= {out_b, chain_b[11:1]};
  always @(posedge clk) if (en_c) chain_c <= {out_c, chain_c[31:2]};

  // Drives one full load on instance A and reports what was observed.
  task automatic load_a(input logic [7:0] w0, input logic [7:0] w1, input int stall_len,
                        input bit poke_start, output int en_cnt, output int gap_cnt,
                        output int done_cnt, output logic [15:0] seq, output int last_en,
                        output int done_cyc, output int busy_after, output int tmo);
    int wi;
    int stall_left;
    int cyc;
    bit fin;
    wi = 0; stall_left = stall_len; en_cnt = 0; gap_cnt = 0; done_cnt = 0; seq = '0;
    last_en = -1; done_cyc = -1; busy_after = 0; tmo = 0; fin = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (cyc = 0; cyc < 60 && !fin; cyc++) begin
      word_a  = (wi == 0) ? w0 : w1;
      valid_a = (wi < 2);
      #1;
      if (valid_a && wi == 1 && ready_a && stall_left > 0) begin
        valid_a = 1'b0;
        stall_left--;
      end
      start_a = poke_start && (cyc == 4 || done_a);
      #1;
      if (en_a) begin
        if (en_cnt < 16) seq[en_cnt] = out_a;
        en_cnt++;
        last_en = cyc;
      end else if (en_cnt > 0 && en_cnt < 16) begin
        gap_cnt++;
      end
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
        fin = 1'b1;
      end
      if (valid_a && ready_a) wi++;
      @(negedge clk);
    end
    valid_a = 1'b0;
    start_a = 1'b0;
    if (!fin) tmo = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (done_a) done_cnt++;
      if (en_a) en_cnt++;
      if (busy_a) busy_after++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b1; valid_a = 1'b1; word_a = 8'hFF;
    start_b = 1'b1; valid_b = 1'b1; word_b = 8'hFF;
    start_c = 1'b1; valid_c = 1'b1; word_c = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready_a); end
    checks++; if (en_a !== 1'b0) begin failures++; $display("FAIL reset_en got=%b want=0", en_a); end
    checks++; if (out_a !== 1'b0) begin failures++; $display("FAIL reset_out got=%b want=0", out_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_a); end
    checks++; if (busy_b !== 1'b0 || busy_c !== 1'b0) begin
      failures++; $display("FAIL reset_busy_bc got=%b%b want=00", busy_b, busy_c);
    end
    rst = 1'b0;
    start_a = 1'b0; valid_a = 1'b0;
    start_b = 1'b0; valid_b = 1'b0;
    start_c = 1'b0; valid_c = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b want=0", busy_a); end
  endtask

  task automatic test_back_to_back();
    int en_cnt, gap_cnt, done_cnt, last_en, done_cyc, busy_after, tmo;
    logic [15:0] seq;
    load_a(8'hA5, 8'h3C, 0, 1'b0, en_cnt, gap_cnt, done_cnt, seq, last_en, done_cyc,
           busy_after, tmo);
    checks++; if (tmo !== 0) begin failures++; $display("FAIL b2b_timeout got=%0d want=0", tmo); end
    checks++; if (en_cnt !== 16) begin failures++; $display("FAIL b2b_shifts got=%0d want=16", en_cnt); end
    checks++; if (gap_cnt !== 0) begin failures++; $display("FAIL b2b_gaps got=%0d want=0", gap_cnt); end
    checks++; if (seq !== 16'h3CA5) begin failures++; $display("FAIL b2b_seq got=%h want=3ca5", seq); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL b2b_done_count got=%0d want=1", done_cnt); end
    checks++; if (done_cyc !== last_en + 1) begin
      failures++; $display("FAIL b2b_done_timing got=%0d want=%0d", done_cyc, last_en + 1);
    end
    checks++; if (chain_a !== 16'h3CA5) begin failures++; $display("FAIL b2b_lut got=%h want=3ca5", chain_a); end
    checks++; if (busy_after !== 0) begin failures++; $display("FAIL b2b_idle got=%0d want=0", busy_after); end
  endtask

  task automatic test_starvation();
    int en_cnt, gap_cnt, done_cnt, last_en, done_cyc, busy_after, tmo;
    logic [15:0] seq;
    chain_a = 16'h0000;
    load_a(8'hA5, 8'h3C, 3, 1'b0, en_cnt, gap_cnt, done_cnt, seq, last_en, done_cyc,
           busy_after, tmo);
    checks++; if (tmo !== 0) begin failures++; $display("FAIL starve_timeout got=%0d want=0", tmo); end
    checks++; if (en_cnt !== 16) begin failures++; $display("FAIL starve_shifts got=%0d want=16", en_cnt); end
    checks++; if (gap_cnt !== 3) begin failures++; $display("FAIL starve_gaps got=%0d want=3", gap_cnt); end
    checks++; if (seq !== 16'h3CA5) begin failures++; $display("FAIL starve_seq got=%h want=3ca5", seq); end
    checks++; if (chain_a !== 16'h3CA5) begin failures++; $display("FAIL starve_chain got=%h want=3ca5", chain_a); end
  endtask

  task automatic test_start_ignored();
    int en_cnt, gap_cnt, done_cnt, last_en, done_cyc, busy_after, tmo;
    logic [15:0] seq;
    load_a(8'h5A, 8'hC3, 0, 1'b1, en_cnt, gap_cnt, done_cnt, seq, last_en, done_cyc,
           busy_after, tmo);
    checks++; if (tmo !== 0) begin failures++; $display("FAIL ign_timeout got=%0d want=0", tmo); end
    checks++; if (en_cnt !== 16) begin failures++; $display("FAIL ign_shifts got=%0d want=16", en_cnt); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
    checks++; if (busy_after !== 0) begin failures++; $display("FAIL ign_restart got=%0d want=0", busy_after); end
    checks++; if (seq !== 16'hC35A) begin failures++; $display("FAIL ign_seq got=%h want=c35a", seq); end
  endtask

  task automatic test_reset_mid_load();
    int n;
    int en_cnt, gap_cnt, done_cnt, last_en, done_cyc, busy_after, tmo;
    logic [15:0] seq;
    n = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; word_a = 8'hA5; valid_a = 1'b1;
    for (int g = 0; g < 40 && n < 5; g++) begin
      #1;
      if (en_a) n++;
      @(negedge clk);
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL rml_pre_shifts got=%0d want=5", n); end
    // Reset together with start and a valid word: reset must win.
    rst = 1'b1; start_a = 1'b1; valid_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0; valid_a = 1'b0;
    #1;
    checks++; if ({ready_a, en_a, out_a, busy_a, done_a} !== 5'b0) begin
      failures++;
      $display("FAIL rml_outputs got=%b want=00000", {ready_a, en_a, out_a, busy_a, done_a});
    end
    load_a(8'hA5, 8'h3C, 0, 1'b0, en_cnt, gap_cnt, done_cnt, seq, last_en, done_cyc,
           busy_after, tmo);
    checks++; if (tmo !== 0) begin failures++; $display("FAIL rml_timeout got=%0d want=0", tmo); end
    checks++; if (en_cnt !== 16) begin failures++; $display("FAIL rml_shifts got=%0d want=16", en_cnt); end
    checks++; if (seq !== 16'h3CA5) begin failures++; $display("FAIL rml_seq got=%h want=3ca5", seq); end
    checks++; if (chain_a !== 16'h3CA5) begin failures++; $display("FAIL rml_chain got=%h want=3ca5", chain_a); end
  endtask

  task automatic test_partial_word();
    int wi, en_cnt, done_cnt, late_ready;
    bit fin;
    wi = 0; en_cnt = 0; done_cnt = 0; late_ready = 0; fin = 1'b0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      word_b  = (wi == 0) ? 8'hFF : 8'h0F;
      valid_b = (wi < 2);
      #1;
      if (en_b) en_cnt++;
      if (wi == 2 && ready_b) late_ready++;
      if (done_b) begin done_cnt++; fin = 1'b1; end
      if (valid_b && ready_b) wi++;
      @(negedge clk);
    end
    valid_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (en_b) en_cnt++;
      if (done_b) done_cnt++;
      @(negedge clk);
    end
    checks++; if (!fin) begin failures++; $display("FAIL part_timeout got=0 want=1"); end
    checks++; if (en_cnt !== 12) begin failures++; $display("FAIL part_shifts got=%0d want=12", en_cnt); end
    checks++; if (wi !== 2) begin failures++; $display("FAIL part_words got=%0d want=2", wi); end
    checks++; if (late_ready !== 0) begin failures++; $display("FAIL part_ready got=%0d want=0", late_ready); end
    checks++; if (chain_b !== 12'hFFF) begin failures++; $display("FAIL part_chain got=%h want=fff", chain_b); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL part_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_width2();
    logic [7:0] words [4];
    int wi, en_cnt, done_cnt, gap_cnt;
    logic [1:0] first_out;
    bit fin;
    words[0] = 8'h1B; words[1] = 8'hE4; words[2] = 8'h72; words[3] = 8'h9D;
    wi = 0; en_cnt = 0; done_cnt = 0; gap_cnt = 0; first_out = 2'bxx; fin = 1'b0;
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      word_c  = words[(wi < 4) ? wi : 3];
      valid_c = (wi < 4);
      #1;
      if (en_c) begin
        if (en_cnt == 0) first_out = out_c;
        en_cnt++;
      end else if (en_cnt > 0 && en_cnt < 16) begin
        gap_cnt++;
      end
      if (done_c) begin done_cnt++; fin = 1'b1; end
      if (valid_c && ready_c) wi++;
      @(negedge clk);
    end
    valid_c = 1'b0;
    checks++; if (!fin) begin failures++; $display("FAIL w2_timeout got=0 want=1"); end
    checks++; if (en_cnt !== 16) begin failures++; $display("FAIL w2_shifts got=%0d want=16", en_cnt); end
    checks++; if (gap_cnt !== 0) begin failures++; $display("FAIL w2_gaps got=%0d want=0", gap_cnt); end
    checks++; if (first_out !== 2'b11) begin failures++; $display("FAIL w2_slice0 got=%b want=11", first_out); end
    checks++; if (wi !== 4) begin failures++; $display("FAIL w2_words got=%0d want=4", wi); end
    checks++; if (chain_c !== 32'h9D72E41B) begin
      failures++; $display("FAIL w2_chain got=%h want=9d72e41b", chain_c);
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL w2_done got=%0d want=1", done_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; word_a = '0;
    start_b = 1'b0; valid_b = 1'b0; word_b = '0;
    start_c = 1'b0; valid_c = 1'b0; word_c = '0;
    test_reset();
    test_back_to_back();
    test_starvation();
    test_start_ignored();
    test_reset_mid_load();
    test_partial_word();
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 1: bits shifted into the configuration chain per cycle.
REQ-002 SHALL have parameter WORD_WIDTH, default 32: width of input bitstream words; multiple of CONFIG_WIDTH.
REQ-003 SHALL have parameter CHAIN_LEN, default 16: total configuration bits in the chain; multiple of CONFIG_WIDTH.
REQ-004 SHALL have port config_clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port config_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: begin a load when idle.
REQ-007 SHALL have port word_in, input, WORD_WIDTH: bitstream word.
REQ-008 SHALL have port word_valid, input, 1: word_in valid.
REQ-009 SHALL have port word_ready, output, 1: loader accepts word_in this cycle.
REQ-010 SHALL have port config_en, output, 1: chain shift enable, drives config_en of every chain element.
REQ-011 SHALL have port config_out, output, CONFIG_WIDTH: slice driven into config_in of the first chain element.
REQ-012 SHALL have port busy, output, 1: load in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on load completion.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-015 SHALL transition IDLE->LOAD on the edge sampling start=1; start SHALL be ignored in LOAD and DONE.
REQ-016 SHALL transition LOAD->DONE on the edge completing the shift of slice CHAIN_LEN/CONFIG_WIDTH; DONE->IDLE unconditionally next edge.
REQ-017 SHALL hold a one-word buffer plus slice index; a word transfers on the edge where word_valid=1 and word_ready=1.
REQ-018 SHALL drive word_ready=1 only in LOAD when remaining bits >0 beyond the buffered word and (buffer empty, or buffer's last slice is being shifted this cycle); no bubble between consecutive words.
REQ-019 SHALL drive config_en=1 exactly in LOAD cycles where the buffer holds a word; config_out = current slice, combinational from buffer and index.
REQ-020 SHALL shift slices LSB-first: slice k = word[k*CONFIG_WIDTH +: CONFIG_WIDTH]; first-shifted slice ends deepest in the chain.
REQ-021 SHALL, on buffer starvation in LOAD, hold config_en=0 (chain frozen), keep counters, and resume on next word with no lost or duplicated slice.
REQ-022 SHALL discard unused slices of the final word when the chain count is reached; buffer cleared on entering DONE.
REQ-023 SHALL drive config_out=0 whenever config_en=0.
REQ-024 SHALL assert busy=1 in LOAD and DONE, 0 in IDLE; done=1 only in DONE.
REQ-025 SHALL count shifted slices in a counter of width clog2(CHAIN_LEN/CONFIG_WIDTH+1); no wrap occurs.
REQ-026 SHALL make total config_en=1 cycles per load exactly CHAIN_LEN/CONFIG_WIDTH.

Reset
REQ-027 SHALL, with config_rst=1 at an edge, enter IDLE, clear buffer, index and counter; outputs word_ready=0, config_en=0, config_out=0, busy=0, done=0.
REQ-028 SHALL give config_rst priority over start and word handshakes in the same cycle.
REQ-029 SHALL abort a load on reset mid-LOAD; chain contents are not cleared, next load restarts from slice 0.

Verification (CONFIG_WIDTH=1, WORD_WIDTH=8, CHAIN_LEN=16 unless noted)
REQ-030 SHALL cover back-to-back: start, words 0xA5 then 0x3C with valid held -> 16 consecutive config_en cycles, config_out sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done pulse one cycle after last shift; one 4-input LUT on chain reads table 0x3CA5.
REQ-031 SHALL cover starvation: word_valid dropped 3 cycles after first word -> config_en low exactly 3 cycles, final chain contents identical to REQ-030.
REQ-032 SHALL cover partial final word: CHAIN_LEN=12, words 0xFF, 0x0F -> 12 shifts, upper nibble of 0x0F discarded, word_ready=0 after second word.
REQ-033 SHALL cover start ignored: start pulsed during LOAD and DONE -> no restart, exactly 16 shifts, single done pulse.
REQ-034 SHALL cover reset mid-load: config_rst after 5 shifts -> all outputs 0 next cycle; new start plus two words -> full 16 shifts.
REQ-035 SHALL cover CONFIG_WIDTH=2, CHAIN_LEN=32, WORD_WIDTH=8, four words -> 16 config_en cycles, slice 0 = word_in[1:0] of first word.
